// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch stage feeding control_unit. Holds the PC, issues reads
//   to a 1-cycle registered instruction memory, latches the opcode into ir and
//   flags it with a single-cycle ir_valid pulse. Two-byte branches (opcode +
//   target byte) are resolved here using the captured z flag. end_op freezes
//   the stage until the next start.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin fetching at RESET_PC (IDLE/HALT only)
//   fetch_req    fetch the next opcode (EXEC only)
//   branch_req   current opcode is a branch, operand byte sits at pc (EXEC only)
//   br_uncond    with branch_req: 1 = always taken, 0 = taken iff z
//   z            ALU zero flag, sampled on the branch_req edge
//   end_op       program end, freeze (EXEC only)
//   im_rdata     memory read data, valid the cycle after im_rd_en
//   im_addr      memory address (mirror of pc)
//   im_rd_en     memory read strobe
//   ir           instruction register
//   ir_valid     1-cycle pulse: ir holds a newly fetched opcode
//   pc           program counter
//   busy         fetch or branch resolution in progress
//   halted       frozen after end_op
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fetch_req,
  input  logic              branch_req,
  input  logic              br_uncond,
  input  logic              z,
  input  logic              end_op,
  input  logic [DATA_W-1:0] im_rdata,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_rd_en,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    CAPTURE    = 3'd2,
    EXEC       = 3'd3,
    BR_ISSUE   = 3'd4,
    BR_RESOLVE = 3'd5,
    HALT       = 3'd6
  } state_e;

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic [DATA_W-1:0] ir_q,       ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              rd_en_q,    rd_en_d;
  logic              busy_q,     busy_d;
  logic              halted_q,   halted_d;
  logic              z_cap_q,    z_cap_d;
  logic              unc_cap_q,  unc_cap_d;
  logic              taken_c;

  // Branch decision from the flags captured on the branch_req edge.
  assign taken_c = unc_cap_q | z_cap_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    z_cap_d   = z_cap_q;
    unc_cap_d = unc_cap_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = PC_RST;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        ir_d    = im_rdata;
        pc_d    = pc_q + PC_ONE;
        state_d = EXEC;
      end
      EXEC: begin
        if (end_op) begin
          state_d = HALT;
        end else if (branch_req) begin
          z_cap_d   = z;
          unc_cap_d = br_uncond;
          state_d   = BR_ISSUE;
        end else if (fetch_req) begin
          state_d = ISSUE;
        end
      end
      BR_ISSUE: begin
        state_d = BR_RESOLVE;
      end
      BR_RESOLVE: begin
        // Operand byte is on im_rdata now; the next opcode fetch starts
        // without waiting for another fetch_req.
        pc_d    = taken_c ? ADDR_W'(im_rdata) : pc_q + PC_ONE;
        state_d = ISSUE;
      end
      HALT: begin
        if (start) begin
          pc_d    = PC_RST;
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered status outputs are decoded from the state being entered so
  // they line up with the state itself.
  always_comb begin
    rd_en_d    = (state_d == ISSUE) || (state_d == BR_ISSUE);
    busy_d     = (state_d == ISSUE) || (state_d == CAPTURE) ||
                 (state_d == BR_ISSUE) || (state_d == BR_RESOLVE);
    halted_d   = (state_d == HALT);
    // CAPTURE always leads into EXEC, so this marks only the first EXEC cycle.
    ir_valid_d = (state_q == CAPTURE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= PC_RST;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      z_cap_q    <= 1'b0;
      unc_cap_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      z_cap_q    <= z_cap_d;
      unc_cap_q  <= unc_cap_d;
    end
  end

  assign im_addr  = pc_q;
  assign im_rd_en = rd_en_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc       = pc_q;
  assign busy     = busy_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed plus randomized bench for instr_fetch_unit. A program-level model
//   (program counter, memory image, opcode count) predicts pc, ir and
//   request-to-ir_valid latency; a monitor watches ir_valid pulses and reads
//   while halted.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       fetch_req = 1'b0;
  logic       branch_req = 1'b0;
  logic       br_uncond = 1'b0;
  logic       z = 1'b0;
  logic       end_op = 1'b0;
  logic [7:0] im_rdata = 8'h00;
  logic [7:0] im_addr;
  logic       im_rd_en;
  logic [7:0] ir;
  logic       ir_valid;
  logic [7:0] pc;
  logic       busy;
  logic       halted;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int dbl = 0;
  int rd_halt = 0;
  int addr_mis = 0;
  logic prev_v = 1'b0;

  logic [7:0] mpc;
  logic [7:0] exp_ir;

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .fetch_req  (fetch_req),
    .branch_req (branch_req),
    .br_uncond  (br_uncond),
    .z          (z),
    .end_op     (end_op),
    .im_rdata   (im_rdata),
    .im_addr    (im_addr),
    .im_rd_en   (im_rd_en),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory.
  always @(posedge clk) begin
    if (im_rd_en) im_rdata <= mem[im_addr];
  end

  // Protocol monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (ir_valid) pulses++;
    if (ir_valid && prev_v) dbl++;
    prev_v = ir_valid;
    if (halted && im_rd_en) rd_halt++;
    if (im_addr !== pc) addr_mis++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the ir_valid pulse, then compare latency, ir and pc.
  // chk_n > 0 additionally compares pc at that sample.
  task automatic wait_valid(input string tag, input int exp_n, input int chk_n,
                            input logic [7:0] chk_pc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0; fetch_req = 1'b0; branch_req = 1'b0; end_op = 1'b0;
      z = 1'($urandom_range(0, 1));
      if (n == chk_n) check({tag, " mid pc"}, 32'(pc), 32'(chk_pc));
    end while (!ir_valid && n < 20);
    check({tag, " latency"}, 32'(n), 32'(exp_n));
    check({tag, " ir"}, 32'(ir), 32'(exp_ir));
    check({tag, " pc"}, 32'(pc), 32'(mpc));
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    mpc = 8'h00;
    exp_ir = mem[mpc];
    mpc = mpc + 8'h01;
    exp_pulses++;
    wait_valid(tag, 3, 0, 8'h00);
  endtask

  task automatic do_fetch(input string tag);
    fetch_req = 1'b1;
    exp_ir = mem[mpc];
    mpc = mpc + 8'h01;
    exp_pulses++;
    wait_valid(tag, 3, 0, 8'h00);
  endtask

  task automatic do_branch(input string tag, input logic unc, input logic zv);
    logic taken;
    branch_req = 1'b1;
    br_uncond = unc;
    z = zv;
    taken = unc | zv;
    mpc = taken ? mem[mpc] : mpc + 8'h01;
    begin
      logic [7:0] tgt;
      tgt = mpc;
      exp_ir = mem[mpc];
      mpc = mpc + 8'h01;
      exp_pulses++;
      wait_valid(tag, 5, 3, tgt);
    end
  endtask

  // Stay in EXEC with no request: nothing may move.
  task automatic idle(input string tag, input int k);
    int bad;
    bad = 0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      z = 1'($urandom_range(0, 1));
      br_uncond = 1'($urandom_range(0, 1));
      if (ir_valid || busy || im_rd_en) bad++;
    end
    check({tag, " idle activity"}, 32'(bad), 32'd0);
    check({tag, " idle ir"}, 32'(ir), 32'(exp_ir));
    check({tag, " idle pc"}, 32'(pc), 32'(mpc));
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h01; mem[1] = 8'h02;
    mem[2] = 8'hB0; mem[3] = 8'h10; mem[16] = 8'h04;
    mpc = 8'h00;
    exp_ir = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst pc", 32'(pc), 32'h0);
    check("rst ir", 32'(ir), 32'h0);
    check("rst flags", {28'd0, ir_valid, im_rd_en, busy, halted}, 32'h0);
    rst_n = 1'b1;
    fetch_req = 1'b1;
    repeat (3) @(negedge clk);
    fetch_req = 1'b0;
    check("idle ignores fetch_req", {29'd0, ir_valid, im_rd_en, busy}, 32'h0);

    // Start and sequential fetch
    do_start("t1 start");
    check("t1 ir literal", 32'(ir), 32'h01);
    do_fetch("t1 fetch");
    check("t1 ir2 literal", 32'(ir), 32'h02);
    check("t1 pc2 literal", 32'(pc), 32'h02);
    idle("t1", 3);

    // Branch taken on z
    do_fetch("t2 fetch op");
    do_branch("t2 br z", 1'b0, 1'b1);
    check("t2 ir literal", 32'(ir), 32'h04);
    check("t2 pc literal", 32'(pc), 32'h11);

    // Not taken, then unconditional
    do_branch("t3 nt", 1'b0, 1'b0);
    do_branch("t3 unc", 1'b1, 1'b0);

    // Randomized program walk
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: do_fetch("rnd fetch");
        1: do_branch("rnd br", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        2: begin
          idle("rnd", int'($urandom_range(1, 4)));
          do_fetch("rnd idle fetch");
        end
        default: do_branch("rnd br0", 1'b0, 1'($urandom_range(0, 1)));
      endcase
    end

    // PC wrap: branch to FEh, then FFh -> 00h
    mem[mpc] = 8'hFE;
    do_branch("t5 br", 1'b1, 1'($urandom_range(0, 1)));
    check("t5 pc ff", 32'(pc), 32'hFF);
    do_fetch("t5 wrap");
    check("t5 pc 00", 32'(pc), 32'h00);

    // end_op wins over fetch_req; HALT frozen until start
    end_op = 1'b1;
    fetch_req = 1'b1;
    @(negedge clk);
    end_op = 1'b0;
    check("t4 halt flags", {29'd0, halted, busy, im_rd_en}, 32'h4);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      fetch_req = 1'($urandom_range(0, 1));
      branch_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!halted || busy || ir_valid || im_rd_en) bad++;
    end
    fetch_req = 1'b0;
    branch_req = 1'b0;
    check("t4 halt stable", 32'(bad), 32'd0);
    check("t4 halt pc", 32'(pc), 32'(mpc));
    check("t4 halt ir", 32'(ir), 32'(exp_ir));
    do_start("t4 restart");
    check("t4 ir mem0", 32'(ir), 32'h01);

    // Reset during CAPTURE
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    check("t6 in capture busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6 rst pc", 32'(pc), 32'h0);
    check("t6 rst ir", 32'(ir), 32'h0);
    check("t6 rst flags", {28'd0, ir_valid, im_rd_en, busy, halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mpc = 8'h00;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ir_valid || busy || im_rd_en) bad++;
    end
    check("t6 quiet after reset", 32'(bad), 32'd0);
    do_start("t6 restart");
    do_fetch("t6 fetch");

    // Global protocol properties
    @(negedge clk);
    check("ir_valid pulse count", 32'(pulses), 32'(exp_pulses));
    check("ir_valid back-to-back", 32'(dbl), 32'd0);
    check("read while halted", 32'(rd_halt), 32'd0);
    check("im_addr vs pc", 32'(addr_mis), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
